lsu_ddr3_issue: RTL and testbench

Request-issue stage between the LSU output port and the DDR3 controller, directly upstream of the DDR3 stall controller. It accepts one LSU load/store at a time and keeps a single-line read buffer. Load hits are answered locally; misses and stores become DDR3 commands. It generates the `LSUOut2DDR3_en` and `SAME_i` strobes that the stall controller consumes.

---
 rtl/lsu_ddr3_issue_pkg.sv | 19 +
 rtl/ddr3_line_buf.sv | 44 ++++
 rtl/lsu_ddr3_issue.sv | 138 +++++++++++++
 tb/tb_lsu_ddr3_issue.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_ddr3_issue_pkg.sv
// Shared definitions for the LSU-to-DDR3 issue stage: default widths,
// issue FSM state encoding and the line-offset width derivation.
package lsu_ddr3_issue_pkg;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_LINE_W = 256;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_WR_WAIT = 2'd2,
        ST_RESP    = 2'd3
    } state_t;

    // Number of word-select bits inside one DDR3 line.
    function automatic int calc_off_w(input int line_w, input int data_w);
        return $clog2(line_w / data_w);
    endfunction
endpackage

// File: rtl/ddr3_line_buf.sv
// Single-line read buffer: tag compare, word read mux, line fill and
// masked single-word update for store hits.
module ddr3_line_buf
    import lsu_ddr3_issue_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LINE_W = DEF_LINE_W,
    parameter int OFF_W  = calc_off_w(DEF_LINE_W, DEF_DATA_W),
    parameter int TAG_W  = DEF_ADDR_W - OFF_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [TAG_W-1:0]  tag,
    input  logic [OFF_W-1:0]  sel,
    input  logic              fill_en,
    input  logic [TAG_W-1:0]  fill_tag,
    input  logic [LINE_W-1:0] fill_data,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              hit,
    output logic [DATA_W-1:0] rd_word
);
    logic              buf_valid;
    logic [TAG_W-1:0]  buf_tag;
    logic [LINE_W-1:0] buf_data;

    assign hit     = buf_valid && (buf_tag == tag);
    assign rd_word = buf_data[sel*DATA_W +: DATA_W];

    // A store miss never allocates; only a hit patches the buffered word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            buf_valid <= 1'b0;
            buf_tag   <= '0;
            buf_data  <= '0;
        end else if (fill_en) begin
            buf_valid <= 1'b1;
            buf_tag   <= fill_tag;
            buf_data  <= fill_data;
        end else if (wr_en && hit) begin
            buf_data[sel*DATA_W +: DATA_W] <= wr_data;
        end
    end
endmodule

// File: rtl/lsu_ddr3_issue.sv
// LSU request-issue stage: one request in flight, local load hits, DDR3
// commands for misses and stores, edge-detected DDR3 completions.
module lsu_ddr3_issue
    import lsu_ddr3_issue_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int LINE_W = DEF_LINE_W,
    localparam int OFF_W = calc_off_w(LINE_W, DATA_W),
    localparam int LANES = LINE_W / DATA_W
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    stall_i,
    input  logic                    lsu_valid_i,
    input  logic                    lsu_we_i,
    input  logic [ADDR_W-1:0]       lsu_addr_i,
    input  logic [DATA_W-1:0]       lsu_wdata_i,
    output logic                    lsu_ready_o,
    output logic [DATA_W-1:0]       lsu_rdata_o,
    output logic                    lsu_rvalid_o,
    output logic                    LSUOut2DDR3_en,
    output logic                    SAME_o,
    output logic                    ddr3_cmd_en_o,
    output logic                    ddr3_cmd_we_o,
    output logic [ADDR_W-OFF_W-1:0] ddr3_addr_o,
    output logic [LINE_W-1:0]       ddr3_wdata_o,
    output logic [LANES-1:0]        ddr3_wmask_o,
    input  logic                    DDR3_rdy,
    input  logic [LINE_W-1:0]       ddr3_rdata_i,
    input  logic                    DDR3_w_rdy
);
    state_t                  state;
    logic                    DDR3_rdy_pre;
    logic                    DDR3_w_rdy_pre;
    logic [ADDR_W-OFF_W-1:0] req_tag;
    logic [OFF_W-1:0]        req_sel;
    logic                    buf_hit;
    logic [DATA_W-1:0]       buf_word;

    wire [ADDR_W-OFF_W-1:0] tag_in = lsu_addr_i[ADDR_W-1:OFF_W];
    wire [OFF_W-1:0]        sel_in = lsu_addr_i[OFF_W-1:0];
    wire accept = lsu_valid_i && (state == ST_IDLE) && !stall_i;

    // Simultaneous edges on both completion inputs are treated as noise.
    wire rd_edge = DDR3_rdy && !DDR3_rdy_pre;
    wire wr_edge = DDR3_w_rdy && !DDR3_w_rdy_pre;
    wire rd_done = (state == ST_RD_WAIT) && rd_edge && !wr_edge;
    wire wr_done = (state == ST_WR_WAIT) && wr_edge && !rd_edge;

    assign lsu_ready_o  = (state == ST_IDLE);
    assign lsu_rvalid_o = (state == ST_RESP) && !stall_i;

    ddr3_line_buf #(
        .DATA_W (DATA_W),
        .LINE_W (LINE_W),
        .OFF_W  (OFF_W),
        .TAG_W  (ADDR_W - OFF_W)
    ) u_line_buf (
        .clk       (clk),
        .reset_n   (reset_n),
        .tag       (tag_in),
        .sel       (sel_in),
        .fill_en   (rd_done),
        .fill_tag  (req_tag),
        .fill_data (ddr3_rdata_i),
        .wr_en     (accept && lsu_we_i),
        .wr_data   (lsu_wdata_i),
        .hit       (buf_hit),
        .rd_word   (buf_word)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            DDR3_rdy_pre   <= 1'b0;
            DDR3_w_rdy_pre <= 1'b0;
            req_tag        <= '0;
            req_sel        <= '0;
            lsu_rdata_o    <= '0;
            LSUOut2DDR3_en <= 1'b0;
            SAME_o         <= 1'b0;
            ddr3_cmd_en_o  <= 1'b0;
            ddr3_cmd_we_o  <= 1'b0;
            ddr3_addr_o    <= '0;
            ddr3_wdata_o   <= '0;
            ddr3_wmask_o   <= '0;
        end else begin
            DDR3_rdy_pre   <= DDR3_rdy;
            DDR3_w_rdy_pre <= DDR3_w_rdy;
            LSUOut2DDR3_en <= 1'b0;
            SAME_o         <= 1'b0;
            ddr3_cmd_en_o  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        req_tag <= tag_in;
                        req_sel <= sel_in;
                        if (lsu_we_i) begin
                            LSUOut2DDR3_en <= 1'b1;
                            ddr3_cmd_en_o  <= 1'b1;
                            ddr3_cmd_we_o  <= 1'b1;
                            ddr3_addr_o    <= tag_in;
                            ddr3_wdata_o   <= {LANES{lsu_wdata_i}};
                            ddr3_wmask_o   <= LANES'(1) << sel_in;
                            state          <= ST_WR_WAIT;
                        end else if (buf_hit) begin
                            SAME_o      <= 1'b1;
                            lsu_rdata_o <= buf_word;
                            state       <= ST_RESP;
                        end else begin
                            LSUOut2DDR3_en <= 1'b1;
                            ddr3_cmd_en_o  <= 1'b1;
                            ddr3_cmd_we_o  <= 1'b0;
                            ddr3_addr_o    <= tag_in;
                            ddr3_wdata_o   <= '0;
                            ddr3_wmask_o   <= '0;
                            state          <= ST_RD_WAIT;
                        end
                    end
                end
                ST_RD_WAIT: begin
                    if (rd_done) begin
                        lsu_rdata_o <= ddr3_rdata_i[req_sel*DATA_W +: DATA_W];
                        state       <= ST_RESP;
                    end
                end
                ST_WR_WAIT: begin
                    if (wr_done) state <= ST_IDLE;
                end
                ST_RESP: begin
                    if (!stall_i) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_ddr3_issue.sv
// Directed bench for lsu_ddr3_issue: fills, hits, store hit, stall,
// edge qualification and mid-transaction reset.
module tb_lsu_ddr3_issue;
    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         stall_i = 1'b0;
    logic         lsu_valid_i = 1'b0;
    logic         lsu_we_i = 1'b0;
    logic [31:0]  lsu_addr_i = '0;
    logic [31:0]  lsu_wdata_i = '0;
    logic         lsu_ready_o;
    logic [31:0]  lsu_rdata_o;
    logic         lsu_rvalid_o;
    logic         LSUOut2DDR3_en;
    logic         SAME_o;
    logic         ddr3_cmd_en_o;
    logic         ddr3_cmd_we_o;
    logic [26:0]  ddr3_addr_o;
    logic [255:0] ddr3_wdata_o;
    logic [7:0]   ddr3_wmask_o;
    logic         DDR3_rdy = 1'b0;
    logic [255:0] ddr3_rdata_i = '0;
    logic         DDR3_w_rdy = 1'b0;

    int total = 0;
    int bad = 0;

    lsu_ddr3_issue dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .stall_i        (stall_i),
        .lsu_valid_i    (lsu_valid_i),
        .lsu_we_i       (lsu_we_i),
        .lsu_addr_i     (lsu_addr_i),
        .lsu_wdata_i    (lsu_wdata_i),
        .lsu_ready_o    (lsu_ready_o),
        .lsu_rdata_o    (lsu_rdata_o),
        .lsu_rvalid_o   (lsu_rvalid_o),
        .LSUOut2DDR3_en (LSUOut2DDR3_en),
        .SAME_o         (SAME_o),
        .ddr3_cmd_en_o  (ddr3_cmd_en_o),
        .ddr3_cmd_we_o  (ddr3_cmd_we_o),
        .ddr3_addr_o    (ddr3_addr_o),
        .ddr3_wdata_o   (ddr3_wdata_o),
        .ddr3_wmask_o   (ddr3_wmask_o),
        .DDR3_rdy       (DDR3_rdy),
        .ddr3_rdata_i   (ddr3_rdata_i),
        .DDR3_w_rdy     (DDR3_w_rdy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        lsu_valid_i = 1'b1;
        lsu_we_i    = we;
        lsu_addr_i  = addr;
        lsu_wdata_i = wdata;
        tick();
        lsu_valid_i = 1'b0;
        lsu_we_i    = 1'b0;
    endtask

    // Word i of a stimulus line is seed ^ (i * 0x01010101).
    function automatic logic [255:0] make_line(input logic [31:0] seed);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = seed ^ (32'h01010101 * 32'(i));
        return l;
    endfunction

    initial begin
        // reset state
        tick_n(2);
        check("rst_ready", lsu_ready_o, 1);
        check("rst_rvalid", lsu_rvalid_o, 0);
        check("rst_same", SAME_o, 0);
        check("rst_cmd_en", ddr3_cmd_en_o, 0);
        check("rst_out_en", LSUOut2DDR3_en, 0);
        check("rst_rdata", lsu_rdata_o, 0);
        check("rst_addr", ddr3_addr_o, 0);
        check("rst_wmask", ddr3_wmask_o, 0);
        reset_n = 1'b1;
        tick();

        // load miss 0x40, fill 5 cycles after the command
        issue(1'b0, 32'h40, '0);
        check("t1_cmd_en", ddr3_cmd_en_o, 1);
        check("t1_out_en", LSUOut2DDR3_en, 1);
        check("t1_cmd_we", ddr3_cmd_we_o, 0);
        check("t1_addr", ddr3_addr_o, 27'h8);
        check("t1_ready", lsu_ready_o, 0);
        tick();
        check("t1_cmd_pulse", ddr3_cmd_en_o, 0);
        tick_n(4);
        DDR3_rdy = 1'b1;
        ddr3_rdata_i = make_line(32'hA5A5A5A5);
        #1;
        check("t1_no_early_rvalid", lsu_rvalid_o, 0);
        tick();
        check("t1_rvalid", lsu_rvalid_o, 1);
        check("t1_rdata", lsu_rdata_o, 32'hA5A5A5A5);
        tick();
        DDR3_rdy = 1'b0;
        check("t1_rvalid_pulse", lsu_rvalid_o, 0);
        check("t1_ready_back", lsu_ready_o, 1);

        // load hit 0x43
        issue(1'b0, 32'h43, '0);
        check("t2_same", SAME_o, 1);
        check("t2_cmd_en", ddr3_cmd_en_o, 0);
        check("t2_rvalid", lsu_rvalid_o, 1);
        check("t2_rdata", lsu_rdata_o, 32'hA6A6A6A6);
        tick();
        check("t2_same_pulse", SAME_o, 0);
        check("t2_ready", lsu_ready_o, 1);

        // store hit 0x45
        issue(1'b1, 32'h45, 32'hDEADBEEF);
        check("t3_cmd_en", ddr3_cmd_en_o, 1);
        check("t3_cmd_we", ddr3_cmd_we_o, 1);
        check("t3_addr", ddr3_addr_o, 27'h8);
        check("t3_wmask", ddr3_wmask_o, 8'h20);
        check("t3_wdata", ddr3_wdata_o[63:0], 64'hDEADBEEF_DEADBEEF);
        tick_n(3);
        DDR3_w_rdy = 1'b1;
        #1;
        check("t3_ready_at_edge", lsu_ready_o, 0);
        tick();
        DDR3_w_rdy = 1'b0;
        check("t3_ready_after", lsu_ready_o, 1);
        issue(1'b0, 32'h45, '0);
        check("t3_hit_same", SAME_o, 1);
        check("t3_hit_rdata", lsu_rdata_o, 32'hDEADBEEF);
        check("t3_hit_rvalid", lsu_rvalid_o, 1);
        tick();

        // stall across a miss completion
        issue(1'b0, 32'h80, '0);
        check("t4_addr", ddr3_addr_o, 27'h10);
        stall_i = 1'b1;
        tick_n(2);
        DDR3_rdy = 1'b1;
        ddr3_rdata_i = make_line(32'h12345678);
        tick();
        check("t4_stalled_1", lsu_rvalid_o, 0);
        tick();
        check("t4_stalled_2", lsu_rvalid_o, 0);
        stall_i = 1'b0;
        #1;
        check("t4_rvalid", lsu_rvalid_o, 1);
        check("t4_rdata", lsu_rdata_o, 32'h12345678);
        tick();
        check("t4_single_pulse", lsu_rvalid_o, 0);
        check("t4_ready", lsu_ready_o, 1);

        // DDR3_rdy already high when the read command goes out
        ddr3_rdata_i = make_line(32'hCAFEF00D);
        tick();
        issue(1'b0, 32'hC1, '0);
        check("t5_addr", ddr3_addr_o, 27'h18);
        tick_n(2);
        check("t5_level_ignored", lsu_rvalid_o, 0);
        check("t5_still_busy", lsu_ready_o, 0);
        DDR3_rdy = 1'b0;
        tick();
        DDR3_rdy = 1'b1;
        tick();
        check("t5_rvalid", lsu_rvalid_o, 1);
        check("t5_rdata", lsu_rdata_o, 32'hCBFFF10C);
        tick();
        DDR3_rdy = 1'b0;
        tick();

        // spurious write edge and simultaneous edges during RD_WAIT
        issue(1'b0, 32'h101, '0);
        check("t5b_addr", ddr3_addr_o, 27'h20);
        DDR3_w_rdy = 1'b1;
        tick();
        check("t5b_wedge_ignored", lsu_ready_o, 0);
        DDR3_w_rdy = 1'b0;
        tick();
        ddr3_rdata_i = make_line(32'h0BADCAFE);
        DDR3_rdy = 1'b1;
        DDR3_w_rdy = 1'b1;
        tick();
        check("t5b_both_rvalid", lsu_rvalid_o, 0);
        check("t5b_both_ready", lsu_ready_o, 0);
        DDR3_rdy = 1'b0;
        DDR3_w_rdy = 1'b0;
        tick();
        DDR3_rdy = 1'b1;
        tick();
        check("t5b_rvalid", lsu_rvalid_o, 1);
        check("t5b_rdata", lsu_rdata_o, 32'h0AACCBFF);
        tick();
        DDR3_rdy = 1'b0;
        tick();

        // reset during WR_WAIT, then a late write completion
        issue(1'b1, 32'h102, 32'h11112222);
        check("t6_cmd_en", ddr3_cmd_en_o, 1);
        tick();
        reset_n = 1'b0;
        #1;
        check("t6_rst_ready", lsu_ready_o, 1);
        check("t6_rst_cmd_we", ddr3_cmd_we_o, 0);
        check("t6_rst_addr", ddr3_addr_o, 0);
        check("t6_rst_wmask", ddr3_wmask_o, 0);
        check("t6_rst_rdata", lsu_rdata_o, 0);
        tick();
        reset_n = 1'b1;
        DDR3_w_rdy = 1'b1;
        tick();
        check("t6_late_wr_ignored", lsu_ready_o, 1);
        DDR3_w_rdy = 1'b0;
        tick();
        issue(1'b0, 32'h101, '0);
        check("t6_miss_same", SAME_o, 0);
        check("t6_miss_cmd", ddr3_cmd_en_o, 1);
        check("t6_miss_addr", ddr3_addr_o, 27'h20);
        tick();
        DDR3_rdy = 1'b1;
        tick();
        check("t6_refill_rdata", lsu_rdata_o, 32'h0AACCBFF);
        tick();
        DDR3_rdy = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got=running exp=done");
        $fatal(1, "timeout");
    end
endmodule
